// File: rtl/perceptron_pkg.sv
// perceptron_pkg: FSM states and datapath widths shared by the perceptron sequencer
// and the perceptron/multiplication datapath.
package perceptron_pkg;
   localparam int DATA_W = 24;
   localparam int COEF_W = 16;
   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_WAIT_LAST,
      S_OUT,
      S_DONE
   } state_t;
endpackage

// File: rtl/seq_addr_gen.sv
// seq_addr_gen: neuron and input-index counters producing weight/activation read addresses.
// Ports: clk/reset (async, active-high); i_clr restarts the layer; i_inc_k steps the input index;
//   i_next moves to the next neuron; i_num_in/i_num_out are the latched layer sizes;
//   o_w_addr/o_act_addr are the read addresses; o_last_k/o_last_n flag the final input/neuron.
module seq_addr_gen #(
   parameter int IN_W   = 8,
   parameter int OUT_W  = 8,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_clr,
   input  logic              i_inc_k,
   input  logic              i_next,
   input  logic [IN_W-1:0]   i_num_in,
   input  logic [OUT_W-1:0]  i_num_out,
   output logic [ADDR_W-1:0] o_w_addr,
   output logic [ADDR_W-1:0] o_act_addr,
   output logic              o_last_k,
   output logic              o_last_n
);
   logic [IN_W-1:0]   r_k;
   logic [OUT_W-1:0]  r_n;
   logic [ADDR_W-1:0] r_base;

   // r_base tracks neuron*num_in by repeated addition, so no multiplier is needed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_k    <= '0;
         r_n    <= '0;
         r_base <= '0;
      end else if (i_clr) begin
         r_k    <= '0;
         r_n    <= '0;
         r_base <= '0;
      end else if (i_next) begin
         r_k    <= '0;
         r_n    <= r_n + OUT_W'(1);
         r_base <= r_base + ADDR_W'(i_num_in);
      end else if (i_inc_k) begin
         r_k    <= r_k + IN_W'(1);
      end
   end

   assign o_w_addr   = r_base + ADDR_W'(r_k);
   assign o_act_addr = ADDR_W'(r_k);
   assign o_last_k   = r_k == i_num_in - IN_W'(1);
   assign o_last_n   = r_n == i_num_out - OUT_W'(1);
endmodule

// File: rtl/perceptron_sequencer.sv
// perceptron_sequencer: drives one shared MAC datapath through a fully-connected layer.
// Ports: clk/reset (async, active-high); start/mode_in/num_in/num_out layer config (latched at start);
//   busy/done layer status; rd_en/w_addr/act_addr weight and activation SRAM reads;
//   mode/acc drive the perceptron, mac_out is its combinational result;
//   res_valid/res_ready/res_data carry one result per neuron.
// Build option: PERCEPTRON_SEQ_RELU_EN clamps negative results to zero on res_data (acc is never clamped).
module perceptron_sequencer
   import perceptron_pkg::*;
#(
   parameter int IN_W   = 8,
   parameter int OUT_W  = 8,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode_in,
   input  logic [IN_W-1:0]   num_in,
   input  logic [OUT_W-1:0]  num_out,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] w_addr,
   output logic [ADDR_W-1:0] act_addr,
   output logic              mode,
   output logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] mac_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data
);
   state_t            r_state;
   logic [IN_W-1:0]   r_num_in;
   logic [OUT_W-1:0]  r_num_out;
   logic              r_busy, r_done, r_rd_en, r_mode, r_acc_we, r_res_valid;
   logic [DATA_W-1:0] r_acc, r_res_data, w_acc_nxt, w_res;
   logic              w_last_k, w_last_n;

   // read data lands one cycle after rd_en, so mac_out is only meaningful while r_acc_we is set
   assign w_acc_nxt = (r_state == S_CLEAR) ? '0 : r_acc_we ? mac_out : r_acc;
`ifdef PERCEPTRON_SEQ_RELU_EN
   assign w_res = w_acc_nxt[DATA_W-1] ? '0 : w_acc_nxt;
`else
   assign w_res = w_acc_nxt;
`endif

   seq_addr_gen #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) u_addr (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (r_state == S_IDLE && start),
      .i_inc_k   (r_state == S_RUN && !w_last_k),
      .i_next    (r_state == S_OUT && res_ready),
      .i_num_in  (r_num_in),
      .i_num_out (r_num_out),
      .o_w_addr  (w_addr),
      .o_act_addr(act_addr),
      .o_last_k  (w_last_k),
      .o_last_n  (w_last_n)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_num_in    <= '0;
         r_num_out   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_rd_en     <= 1'b0;
         r_mode      <= 1'b0;
         r_acc_we    <= 1'b0;
         r_acc       <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
      end else begin
         r_acc    <= w_acc_nxt;
         r_acc_we <= r_rd_en;
         r_done   <= 1'b0;
         case (r_state)
            S_IDLE: if (start) begin
               r_mode    <= mode_in;
               r_num_in  <= num_in;
               r_num_out <= num_out;
               r_busy    <= 1'b1;
               r_done    <= num_out == '0;
               r_state   <= (num_out == '0) ? S_DONE : S_CLEAR;
            end
            S_CLEAR: if (r_num_in == '0) begin
               r_res_valid <= 1'b1;
               r_res_data  <= w_res;
               r_state     <= S_OUT;
            end else begin
               r_rd_en <= 1'b1;
               r_state <= S_RUN;
            end
            S_RUN: if (w_last_k) begin
               r_rd_en <= 1'b0;
               r_state <= S_WAIT_LAST;
            end
            S_WAIT_LAST: begin
               r_res_valid <= 1'b1;
               r_res_data  <= w_res;
               r_state     <= S_OUT;
            end
            S_OUT: if (res_ready) begin
               r_res_valid <= 1'b0;
               r_done      <= w_last_n;
               r_state     <= w_last_n ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign rd_en     = r_rd_en;
   assign mode      = r_mode;
   assign acc       = r_acc;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
endmodule

// File: tb/tb_perceptron_sequencer.sv
// tb_perceptron_sequencer: scoreboard bench with SRAM + MAC model and a layer-level reference model.
module tb_perceptron_sequencer;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, mode_in = 1'b0, res_ready = 1'b1;
   logic [7:0] num_in = '0, num_out = '0;
   logic busy, done, rd_en, mode, res_valid;
   logic [15:0] w_addr, act_addr;
   logic [23:0] acc, mac_out, res_data;
   logic signed [15:0] wmem [256];
   logic signed [15:0] amem [256];
   logic signed [15:0] rd_w, rd_a;
   logic signed [31:0] prod;
   int n_vec = 0, n_err = 0, done_cnt = 0, stall_left = 0;
   bit rnd_ready = 1'b0, exp_mode = 1'b0, prev_stall = 1'b0;
   logic [23:0] prev_data, prev_acc;
   int wq[$], aq[$];
   logic [23:0] rq[$];

   always #5 clk = ~clk;

   perceptron_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .mode_in(mode_in), .num_in(num_in), .num_out(num_out),
      .busy(busy), .done(done), .rd_en(rd_en), .w_addr(w_addr), .act_addr(act_addr), .mode(mode),
      .acc(acc), .mac_out(mac_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   // SRAMs with one-cycle read latency feeding a combinational perceptron: out = acc + w*a
   always @(posedge clk) if (rd_en) begin
      rd_w <= wmem[w_addr[7:0]];
      rd_a <= amem[act_addr[7:0]];
   end
   assign prod    = rd_w * rd_a;
   assign mac_out = acc + prod[23:0];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic logic [23:0] relu(input logic [23:0] v);
`ifdef PERCEPTRON_SEQ_RELU_EN
      return v[23] ? 24'd0 : v;
`else
      return v;
`endif
   endfunction

   // reference: every neuron is a dot product of its weight row with the activation vector
   task automatic prep(input int ni, input int no, input bit md);
      exp_mode = md;
      for (int n = 0; n < no; n++) begin
         int s = 0;
         for (int k = 0; k < ni; k++) begin
            wq.push_back(n * ni + k);
            aq.push_back(k);
            s += int'(wmem[n * ni + k]) * int'(amem[k]);
         end
         rq.push_back(relu(s[23:0]));
      end
   endtask

   task automatic kick(input int ni, input int no, input bit md);
      @(posedge clk); #1;
      start = 1'b1; mode_in = md; num_in = 8'(ni); num_out = 8'(no);
      @(posedge clk); #1;
      start = 1'b0; mode_in = ~md; num_in = 8'($urandom); num_out = 8'($urandom);
   endtask

   task automatic run_layer(input int ni, input int no, input bit md, input bit rr, input bit inj);
      int d0, cyc;
      rnd_ready = rr;
      prep(ni, no, md);
      d0 = done_cnt;
      kick(ni, no, md);
      @(negedge clk);
      chk("busy_after_start", busy, 1);
      if (no == 0) chk("done_next_cycle", done, 1);
      cyc = 0;
      while (done_cnt == d0 && cyc < 3000) begin
         @(posedge clk);
         cyc++;
         #1 start = inj && cyc == 3 && busy;
      end
      start = 1'b0;
      if (cyc >= 3000) chk("done_timeout", 0, 1);
      @(negedge clk);
      chk("busy_fall", busy, 0);
      chk("done_width", done, 0);
      chk("results_left", rq.size(), 0);
      chk("reads_left", wq.size(), 0);
      chk("done_count", done_cnt - d0, 1);
   endtask

   // monitor: address scoreboard, result scoreboard, stall stability, mode and done checks
   initial forever begin
      @(negedge clk);
      if (rd_en) begin
         if (wq.size() == 0) chk("unexpected_read", 1, 0);
         else begin
            chk("w_addr", w_addr, wq.pop_front());
            chk("act_addr", act_addr, aq.pop_front());
         end
      end
      if (res_valid && prev_stall) begin
         chk("hold_data", res_data, prev_data);
         chk("hold_acc", acc, prev_acc);
         chk("hold_no_read", rd_en, 0);
      end
      prev_stall = res_valid && !res_ready;
      prev_data  = res_data;
      prev_acc   = acc;
      if (res_valid && res_ready) begin
         if (rq.size() == 0) chk("unexpected_result", 1, 0);
         else chk("res_data", res_data, rq.pop_front());
      end
      if (busy) chk("mode", mode, exp_mode);
      if (done) begin
         done_cnt++;
         chk("done_after_results", rq.size(), 0);
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (stall_left > 0 && res_valid) begin
         res_ready = 1'b0;
         stall_left--;
      end else res_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   initial begin
      int d0, cyc;
      for (int i = 0; i < 256; i++) begin wmem[i] = '0; amem[i] = '0; end
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_rd_en", rd_en, 0);
      chk("rst_w_addr", w_addr, 0); chk("rst_act_addr", act_addr, 0); chk("rst_mode", mode, 0);
      chk("rst_acc", acc, 0); chk("rst_res_valid", res_valid, 0); chk("rst_res_data", res_data, 0);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) wmem[i] = 16'(i + 1);
      for (int i = 0; i < 3; i++) amem[i] = 16'sd1;
      run_layer(3, 2, 1'b0, 1'b0, 1'b0);
      run_layer(3, 2, 1'b1, 1'b0, 1'b1);
      stall_left = 5;
      run_layer(3, 2, 1'b0, 1'b0, 1'b0);
      run_layer(0, 1, 1'b1, 1'b0, 1'b0);
      run_layer(0, 0, 1'b0, 1'b0, 1'b0);
      wmem[0] = -16'sd5;
      run_layer(1, 1, 1'b0, 1'b0, 1'b0);
      // asynchronous reset in the middle of a layer
      for (int i = 0; i < 12; i++) wmem[i] = 16'($urandom_range(0, 255) - 128);
      prep(6, 2, 1'b1);
      d0 = done_cnt;
      kick(6, 2, 1'b1);
      cyc = 0;
      while (!rd_en && cyc < 50) begin @(negedge clk); cyc++; end
      chk("reach_run", rd_en, 1);
      #2 reset = 1'b1;
      #1;
      chk("mid_busy", busy, 0); chk("mid_done", done, 0); chk("mid_rd_en", rd_en, 0);
      chk("mid_w_addr", w_addr, 0); chk("mid_act_addr", act_addr, 0); chk("mid_mode", mode, 0);
      chk("mid_acc", acc, 0); chk("mid_res_valid", res_valid, 0); chk("mid_res_data", res_data, 0);
      wq.delete(); aq.delete(); rq.delete();
      prev_stall = 1'b0;
      @(negedge clk) reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("no_done_after_reset", done_cnt - d0, 0);
      run_layer(6, 2, 1'b1, 1'b0, 1'b0);
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < 64; i++) begin
            wmem[i] = (t % 2 == 0) ? 16'($urandom_range(0, 255) - 128) : 16'($urandom);
            amem[i] = (t % 2 == 0) ? 16'($urandom_range(0, 255) - 128) : 16'($urandom);
         end
         run_layer($urandom_range(0, 8), $urandom_range(0, 5), 1'($urandom), 1'b1, 1'($urandom));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
